// File: rtl/wishbone_nslave_interconnect_if.sv
// Bus bundle between one Wishbone master, the interconnect and N slaves.
// The "slave" modport is the interconnect's view; "master" is everything around it.
interface wishbone_nslave_interconnect_if #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                             m_we_i;
  logic                             m_cyc_i;
  logic                             m_stb_i;
  logic [ADDR_WIDTH-1:0]            m_adr_i;
  logic [DATA_WIDTH-1:0]            m_dat_i;
  logic [DATA_WIDTH-1:0]            m_dat_o;
  logic                             m_ack_o;
  logic                             m_err_o;
  logic                             m_int_o;
  logic [NUM_SLAVES-1:0]            s_we_o;
  logic [NUM_SLAVES-1:0]            s_cyc_o;
  logic [NUM_SLAVES-1:0]            s_stb_o;
  logic [ADDR_WIDTH-1:0]            s_adr_o;
  logic [DATA_WIDTH-1:0]            s_dat_o;
  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_dat_i;
  logic [NUM_SLAVES-1:0]            s_ack_i;
  logic [NUM_SLAVES-1:0]            s_int_i;

  modport master (
    output m_we_i, m_cyc_i, m_stb_i, m_adr_i, m_dat_i,
    input  m_dat_o, m_ack_o, m_err_o, m_int_o,
    input  s_we_o, s_cyc_o, s_stb_o, s_adr_o, s_dat_o,
    output s_dat_i, s_ack_i, s_int_i
  );

  modport slave (
    input  m_we_i, m_cyc_i, m_stb_i, m_adr_i, m_dat_i,
    output m_dat_o, m_ack_o, m_err_o, m_int_o,
    output s_we_o, s_cyc_o, s_stb_o, s_adr_o, s_dat_o,
    input  s_dat_i, s_ack_i, s_int_i
  );
endinterface

// File: rtl/wishbone_nslave_interconnect.sv
// Single-master, N-slave Wishbone classic interconnect: address-field decode, registered
// handshake, timeout/unmapped error abort and registered interrupt aggregation.
module wishbone_nslave_interconnect #(
  parameter int NUM_SLAVES     = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int SEL_MSB        = 31,
  parameter int SEL_LSB        = 24,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic                         clk,
  input logic                         rst,
  wishbone_nslave_interconnect_if.slave bus
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, ACTIVE, RELEASE} state_t;

  state_t                state;
  logic [IDX_W-1:0]      sel_idx;
  logic [CNT_W-1:0]      timeout_cnt;
  logic [31:0]           req_sel;
  logic                  req_mapped;
  logic [NUM_SLAVES-1:0] req_onehot;
  logic [DATA_WIDTH-1:0] sel_dat;
  logic                  sel_ack;
  logic [ADDR_WIDTH-1:0] masked_adr;

  assign req_sel    = 32'(bus.m_adr_i[SEL_MSB:SEL_LSB]);
  assign req_mapped = (req_sel < NUM_SLAVES);

  // Slaves see the address with the select field zeroed so each decodes from offset 0.
  always_comb begin
    masked_adr = bus.m_adr_i;
    masked_adr[SEL_MSB:SEL_LSB] = '0;
  end

  assign bus.s_adr_o = masked_adr;
  assign bus.s_dat_o = bus.m_dat_i;

  always_comb begin
    req_onehot = '0;
    sel_dat    = '0;
    sel_ack    = 1'b0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      req_onehot[k] = (req_sel == k);
      if (sel_idx == IDX_W'(k)) begin
        sel_dat = bus.s_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
        sel_ack = bus.s_ack_i[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sel_idx     <= '0;
      timeout_cnt <= '0;
      bus.s_cyc_o <= '0;
      bus.s_stb_o <= '0;
      bus.s_we_o  <= '0;
      bus.m_ack_o <= 1'b0;
      bus.m_err_o <= 1'b0;
      bus.m_dat_o <= '0;
      bus.m_int_o <= 1'b0;
    end else begin
      bus.m_int_o <= |bus.s_int_i;
      bus.m_ack_o <= 1'b0;
      bus.m_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.m_cyc_i && bus.m_stb_i) begin
            if (req_mapped) begin
              sel_idx     <= IDX_W'(req_sel);
              timeout_cnt <= CNT_W'(TIMEOUT_CYCLES - 1);
              bus.s_cyc_o <= req_onehot;
              bus.s_stb_o <= req_onehot;
              bus.s_we_o  <= bus.m_we_i ? req_onehot : '0;
              state       <= ACTIVE;
            end else begin
              bus.m_err_o <= 1'b1;
              state       <= RELEASE;
            end
          end
        end
        ACTIVE: begin
          // Master abort takes precedence; an ack on the last count cycle still beats the timeout.
          if (!bus.m_cyc_i) begin
            bus.s_cyc_o <= '0;
            bus.s_stb_o <= '0;
            bus.s_we_o  <= '0;
            state       <= IDLE;
          end else if (sel_ack) begin
            bus.s_cyc_o <= '0;
            bus.s_stb_o <= '0;
            bus.s_we_o  <= '0;
            bus.m_ack_o <= 1'b1;
            bus.m_dat_o <= sel_dat;
            state       <= RELEASE;
          end else if (timeout_cnt == '0) begin
            bus.s_cyc_o <= '0;
            bus.s_stb_o <= '0;
            bus.s_we_o  <= '0;
            bus.m_err_o <= 1'b1;
            bus.m_dat_o <= '0;
            state       <= RELEASE;
          end else begin
            timeout_cnt <= timeout_cnt - CNT_W'(1);
          end
        end
        RELEASE: begin
          if (!bus.m_stb_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wishbone_nslave_interconnect.sv
// Self-checking bench for wishbone_nslave_interconnect: directed scenarios followed by
// randomized transactions checked against a timing/decode reference model.
module tb_wishbone_nslave_interconnect;

  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int T  = 8;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  wishbone_nslave_interconnect_if #(.NUM_SLAVES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  wishbone_nslave_interconnect #(
    .NUM_SLAVES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .SEL_MSB(31), .SEL_LSB(24), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] adr, input logic we, input logic [31:0] dat);
    bus.m_adr_i = adr;
    bus.m_we_i  = we;
    bus.m_dat_i = dat;
    bus.m_cyc_i = 1'b1;
    bus.m_stb_i = 1'b1;
  endtask

  task automatic releaseBus();
    bus.m_cyc_i = 1'b0;
    bus.m_stb_i = 1'b0;
    bus.m_we_i  = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    int          n;
    int          sel;
    int          d;
    logic        we;
    logic [31:0] wdat;
    logic [31:0] rdat;
    logic [23:0] low;
    logic [7:0]  sel8;
    logic [3:0]  exp_onehot;
    logic        done;

    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    bus.m_we_i   = 1'b0;
    bus.m_cyc_i  = 1'b0;
    bus.m_stb_i  = 1'b0;
    bus.m_adr_i  = '0;
    bus.m_dat_i  = '0;
    bus.s_dat_i  = '0;
    bus.s_ack_i  = '0;
    bus.s_int_i  = 4'hF;

    // Reset state
    stepCycle();
    stepCycle();
    checkOutput("rst_ack", bus.m_ack_o, 0);
    checkOutput("rst_err", bus.m_err_o, 0);
    checkOutput("rst_int", bus.m_int_o, 0);
    checkOutput("rst_dat", bus.m_dat_o, 0);
    checkOutput("rst_stb", bus.s_stb_o, 0);
    checkOutput("rst_cyc", bus.s_cyc_o, 0);
    checkOutput("rst_we", bus.s_we_o, 0);
    bus.s_int_i = '0;
    rst = 1'b0;
    stepCycle();

    // Read slave 2, acked 3 cycles after strobe; a stray ack on slave 0 is ignored
    applyStimulus(32'h0200_0010, 1'b0, 32'h0);
    stepCycle();
    checkOutput("rd_stb", bus.s_stb_o, 4'b0100);
    checkOutput("rd_cyc", bus.s_cyc_o, 4'b0100);
    checkOutput("rd_we", bus.s_we_o, 4'b0000);
    checkOutput("rd_adr", bus.s_adr_o, 32'h0000_0010);
    bus.s_ack_i = 4'b0001;
    bus.s_dat_i[0 +: 32] = 32'hDEAD_BEEF;
    stepCycle();
    bus.s_ack_i = '0;
    checkOutput("rd_stray_ack", bus.m_ack_o, 0);
    checkOutput("rd_stb_hold", bus.s_stb_o, 4'b0100);
    stepCycle();
    bus.s_ack_i = 4'b0100;
    bus.s_dat_i[64 +: 32] = 32'hCAFE_F00D;
    checkOutput("rd_ack_early", bus.m_ack_o, 0);
    stepCycle();
    bus.s_ack_i = '0;
    checkOutput("rd_ack", bus.m_ack_o, 1);
    checkOutput("rd_dat", bus.m_dat_o, 32'hCAFE_F00D);
    checkOutput("rd_stb_clr", bus.s_stb_o, 0);
    releaseBus();
    stepCycle();
    checkOutput("rd_ack_pulse", bus.m_ack_o, 0);
    checkOutput("rd_dat_hold", bus.m_dat_o, 32'hCAFE_F00D);

    // Write slave 0; strobe held after ack must not produce a second ack
    applyStimulus(32'h0000_0040, 1'b1, 32'h1234_5678);
    stepCycle();
    checkOutput("wr_we", bus.s_we_o, 4'b0001);
    checkOutput("wr_stb", bus.s_stb_o, 4'b0001);
    checkOutput("wr_sdat", bus.s_dat_o, 32'h1234_5678);
    bus.s_ack_i = 4'b0001;
    stepCycle();
    bus.s_ack_i = '0;
    checkOutput("wr_ack", bus.m_ack_o, 1);
    stepCycle();
    checkOutput("wr_ack_once", bus.m_ack_o, 0);
    checkOutput("wr_no_restart", bus.s_stb_o, 0);
    stepCycle();
    checkOutput("wr_no_reuse", bus.m_ack_o, 0);
    releaseBus();
    stepCycle();

    // Unmapped select
    applyStimulus(32'h0700_0000, 1'b0, 32'h0);
    stepCycle();
    checkOutput("unm_err", bus.m_err_o, 1);
    checkOutput("unm_stb", bus.s_stb_o, 0);
    releaseBus();
    stepCycle();
    checkOutput("unm_err_pulse", bus.m_err_o, 0);

    // Timeout: slave 1 never acks
    applyStimulus(32'h0100_0000, 1'b0, 32'h0);
    stepCycle();
    checkOutput("to_stb", bus.s_stb_o, 4'b0010);
    n = 0;
    for (int c = 1; c <= T + 4; c++) begin
      stepCycle();
      if (bus.m_err_o) begin
        n = c;
        break;
      end
    end
    checkOutput("to_latency", n, T);
    checkOutput("to_stb_clr", bus.s_stb_o, 0);
    checkOutput("to_dat", bus.m_dat_o, 0);
    releaseBus();
    stepCycle();

    // Ack on the final count cycle wins over the timeout
    applyStimulus(32'h0100_0000, 1'b0, 32'h0);
    stepCycle();
    for (int c = 0; c < T - 1; c++) stepCycle();
    bus.s_ack_i = 4'b0010;
    bus.s_dat_i[32 +: 32] = 32'h0BAD_CAFE;
    stepCycle();
    bus.s_ack_i = '0;
    checkOutput("to_edge_ack", bus.m_ack_o, 1);
    checkOutput("to_edge_err", bus.m_err_o, 0);
    checkOutput("to_edge_dat", bus.m_dat_o, 32'h0BAD_CAFE);
    releaseBus();
    stepCycle();

    // Master abort
    applyStimulus(32'h0300_0000, 1'b0, 32'h0);
    stepCycle();
    checkOutput("ab_stb", bus.s_stb_o, 4'b1000);
    releaseBus();
    stepCycle();
    checkOutput("ab_stb_clr", bus.s_stb_o, 0);
    checkOutput("ab_ack", bus.m_ack_o, 0);
    checkOutput("ab_err", bus.m_err_o, 0);
    stepCycle();

    // Reset mid-transaction drops the transfer even with a slave ack present
    applyStimulus(32'h0300_0000, 1'b0, 32'h0);
    stepCycle();
    rst = 1'b1;
    bus.s_ack_i = 4'b1000;
    stepCycle();
    checkOutput("mr_stb", bus.s_stb_o, 0);
    checkOutput("mr_ack", bus.m_ack_o, 0);
    checkOutput("mr_err", bus.m_err_o, 0);
    rst = 1'b0;
    bus.s_ack_i = '0;
    releaseBus();
    stepCycle();
    applyStimulus(32'h0300_0004, 1'b0, 32'h0);
    stepCycle();
    checkOutput("mr_next_stb", bus.s_stb_o, 4'b1000);
    bus.s_ack_i = 4'b1000;
    bus.s_dat_i[96 +: 32] = 32'h5555_AAAA;
    stepCycle();
    bus.s_ack_i = '0;
    checkOutput("mr_next_ack", bus.m_ack_o, 1);
    checkOutput("mr_next_dat", bus.m_dat_o, 32'h5555_AAAA);
    releaseBus();
    stepCycle();

    // Interrupt aggregation
    bus.s_int_i = 4'b0100;
    checkOutput("int_latency", bus.m_int_o, 0);
    stepCycle();
    checkOutput("int_set", bus.m_int_o, 1);
    bus.s_int_i = '0;
    stepCycle();
    checkOutput("int_clr", bus.m_int_o, 0);

    // Randomized transactions: select 4..5 are unmapped; ack delay d counts cycles after strobe
    for (int t = 0; t < 60; t++) begin
      sel  = $urandom_range(0, 5);
      we   = 1'($urandom_range(0, 1));
      wdat = $urandom;
      rdat = $urandom;
      d    = $urandom_range(0, T + 1);
      low  = 24'($urandom);
      sel8 = sel[7:0];
      for (int k = 0; k < NS; k++) bus.s_dat_i[k*32 +: 32] = $urandom;
      bus.s_int_i = 4'($urandom);
      applyStimulus({sel8, low}, we, wdat);
      stepCycle();
      checkOutput("rnd_int", bus.m_int_o, |bus.s_int_i);
      if (sel >= NS) begin
        checkOutput("rnd_unm_err", bus.m_err_o, 1);
        checkOutput("rnd_unm_stb", bus.s_stb_o, 0);
      end else begin
        exp_onehot = 4'(1 << sel);
        checkOutput("rnd_stb", bus.s_stb_o, exp_onehot);
        checkOutput("rnd_we", bus.s_we_o, we ? exp_onehot : 4'b0000);
        checkOutput("rnd_adr", bus.s_adr_o, {8'h00, low});
        checkOutput("rnd_sdat", bus.s_dat_o, wdat);
        done = 1'b0;
        for (int c = 0; c <= T && !done; c++) begin
          bus.s_ack_i = 4'($urandom) & ~exp_onehot;
          if (c == d) begin
            bus.s_ack_i[sel] = 1'b1;
            bus.s_dat_i[sel*32 +: 32] = rdat;
          end
          stepCycle();
          bus.s_ack_i = '0;
          if (d <= T - 1 && c == d) begin
            checkOutput("rnd_ack", bus.m_ack_o, 1);
            checkOutput("rnd_ack_err", bus.m_err_o, 0);
            checkOutput("rnd_rdat", bus.m_dat_o, rdat);
            done = 1'b1;
          end else if (d > T - 1 && c + 1 == T) begin
            checkOutput("rnd_to_err", bus.m_err_o, 1);
            checkOutput("rnd_to_ack", bus.m_ack_o, 0);
            checkOutput("rnd_to_dat", bus.m_dat_o, 0);
            done = 1'b1;
          end else begin
            checkOutput("rnd_wait_ack", bus.m_ack_o, 0);
            checkOutput("rnd_wait_err", bus.m_err_o, 0);
          end
        end
        checkOutput("rnd_done", done, 1);
        checkOutput("rnd_stb_clr", bus.s_stb_o, 0);
      end
      releaseBus();
      stepCycle();
      checkOutput("rnd_pulse_ack", bus.m_ack_o, 0);
      checkOutput("rnd_pulse_err", bus.m_err_o, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
